// File: rtl/fixed_matmul_weight_replay_if.sv
// ----------------------------------------------------------------------------
// fixed_matmul_weight_replay_if
//   Tile stream bundle for the weight replay feeder: one input stream of tiles
//   from the weight source and one output stream towards the matmul core's
//   data_in2 port.
//
//   Parameters
//     WIDTH  element width in bits
//     LANES  elements per tile (IN_SIZE * IN2_PARALLELISM)
//
//   Signals
//     data_in         tile offered by the weight source
//     data_in_valid   data_in is valid
//     data_in_ready   feeder accepts data_in this cycle
//     data_out        replayed tile
//     data_out_valid  data_out is valid
//     data_out_ready  core accepts data_out this cycle
//     data_out_last   final tile of the final pass over the stored matrix
//
//   Modports
//     slave   the feeder itself
//     master  the surrounding environment (weight source plus core)
// ----------------------------------------------------------------------------
interface fixed_matmul_weight_replay_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 3
);
  logic [LANES-1:0][WIDTH-1:0] data_in;
  logic                        data_in_valid;
  logic                        data_in_ready;
  logic [LANES-1:0][WIDTH-1:0] data_out;
  logic                        data_out_valid;
  logic                        data_out_ready;
  logic                        data_out_last;

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last
  );

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last
  );
endinterface

// File: rtl/fixed_matmul_weight_replay.sv
// ----------------------------------------------------------------------------
// fixed_matmul_weight_replay
//   Weight-side feeder for the fixed-point matmul core. Captures one complete
//   second-operand matrix (IN_DEPTH tiles) into a register buffer, then replays
//   the stored tiles in order REPEAT times, once per IN1 row-block the core
//   consumes. The weight source therefore sends each matrix only once.
//
//   Ports
//     clk    clock
//     rst    asynchronous reset, active low
//     bus    fixed_matmul_weight_replay_if.slave
//              data_in / data_in_valid / data_in_ready       tile capture
//              data_out / data_out_valid / data_out_ready    tile replay
//              data_out_last                                 end of final pass
//
//   Optional feature (macro FIXED_MATMUL_WEIGHT_REPLAY_PASSTHROUGH_EN)
//     Defined:   each tile is forwarded to data_out while it is captured and
//                counts as pass 0; REPLAY then emits the remaining REPEAT-1
//                passes. A tile is taken only on a joint input/output
//                handshake. With REPEAT=1 the feeder never leaves FILL.
//     Undefined: FILL is silent and REPLAY emits all REPEAT passes;
//                data_in_ready never depends on data_out_ready.
// ----------------------------------------------------------------------------
module fixed_matmul_weight_replay #(
  parameter int IN2_WIDTH       = 8,
  parameter int IN_SIZE         = 1,
  parameter int IN2_PARALLELISM = 3,
  parameter int IN_DEPTH        = 3,
  parameter int REPEAT          = 2
) (
  input logic                         clk,
  input logic                         rst,
  fixed_matmul_weight_replay_if.slave bus
);

  localparam int LANES = IN_SIZE * IN2_PARALLELISM;
  localparam int PTR_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int CNT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IN_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT - 1);

`ifdef FIXED_MATMUL_WEIGHT_REPLAY_PASSTHROUGH_EN
  // Pass 0 leaves while the matrix is captured, so replay starts at pass 1
  // and is skipped entirely when only one pass is wanted.
  localparam logic [CNT_W-1:0] CNT_FIRST  = CNT_W'(1);
  localparam bit               HAS_REPLAY = (REPEAT > 1);
`else
  localparam logic [CNT_W-1:0] CNT_FIRST  = '0;
  localparam bit               HAS_REPLAY = 1'b1;
`endif

  typedef enum logic {FILL, REPLAY} state_t;
  typedef logic [LANES-1:0][IN2_WIDTH-1:0] tile_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] pass_cnt;
  logic             fill_q;     // input side open; low during and right after reset
  tile_t            mem [IN_DEPTH];

  logic replay_last;
  logic in_hs;
  logic out_hs;

  // Every output below comes from registers only, except in the pass-through
  // build where the forwarded tile is by definition a wire from data_in.
  assign replay_last = (state == REPLAY) && (rd_ptr == PTR_LAST) && (pass_cnt == CNT_LAST);
  assign in_hs       = bus.data_in_valid && bus.data_in_ready;
  assign out_hs      = (state == REPLAY) && bus.data_out_ready;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a signal unassigned and no latch is inferred.
    bus.data_in_ready  = fill_q;
    bus.data_out_valid = (state == REPLAY);
    bus.data_out       = (state == REPLAY) ? mem[rd_ptr] : '0;
    bus.data_out_last  = replay_last;
`ifdef FIXED_MATMUL_WEIGHT_REPLAY_PASSTHROUGH_EN
    if (fill_q) begin
      bus.data_in_ready  = bus.data_out_ready;
      bus.data_out_valid = bus.data_in_valid;
      bus.data_out       = bus.data_in;
      bus.data_out_last  = !HAS_REPLAY && bus.data_in_valid && (wr_ptr == PTR_LAST);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pass_cnt <= '0;
      fill_q   <= 1'b0;
      // NOTE: the buffer is a handful of flops, not a RAM macro, so clearing it
      // in reset is cheap and keeps stale weights from ever reaching the core.
      for (int i = 0; i < IN_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          fill_q <= 1'b1;
          if (in_hs) begin
            mem[wr_ptr] <= bus.data_in;
            if (wr_ptr == PTR_LAST) begin
              wr_ptr   <= '0;
              rd_ptr   <= '0;
              pass_cnt <= CNT_FIRST;
              if (HAS_REPLAY) begin
                state  <= REPLAY;
                fill_q <= 1'b0;
              end
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end

        REPLAY: begin
          if (out_hs) begin
            if (replay_last) begin
              // Matrix fully consumed: reopen the input on the next cycle.
              state    <= FILL;
              fill_q   <= 1'b1;
              rd_ptr   <= '0;
              pass_cnt <= '0;
            end else if (rd_ptr == PTR_LAST) begin
              rd_ptr   <= '0;
              pass_cnt <= pass_cnt + 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule
